// File: rtl/hex_display_sequencer.sv
// Loads a 16-bit value onto four active-low 7-segment digits. One shared decoder
// walks the digits MSB first. The block also does leading-zero blanking and a whole-display blink.
module hex_display_sequencer #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic        ready,
  output logic        done,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_UPDATE = 1'b1;

  localparam int              CNT_W   = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]      SEG_OFF = 7'b1111111;

  logic [0:0]       state_q,     state_d;
  logic [15:0]      shadow_q,    shadow_d;
  logic             lz_mode_q,   lz_mode_d;
  logic [1:0]       idx_q,       idx_d;
  logic             seen_nz_q,   seen_nz_d;
  logic             done_q,      done_d;
  logic [3:0][6:0]  hex_reg_q,   hex_reg_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q,     phase_d;

  logic [3:0] nibble;
  logic [6:0] seg;
  logic       blank_all;

  // The single shared decoder is fed by whichever digit idx currently points at.
  assign nibble = shadow_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    shadow_d  = shadow_q;
    lz_mode_d = lz_mode_q;
    idx_d     = idx_q;
    seen_nz_d = seen_nz_q;
    hex_reg_d = hex_reg_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shadow_d  = value_in;
          lz_mode_d = blank_lz;
          idx_d     = 2'd3;
          seen_nz_d = 1'b0;
          state_d   = ST_UPDATE;
        end
      end
      default: begin
        // Digit 0 is never blanked, so an all-zero value still shows one "0".
        if (lz_mode_q && (nibble == 4'h0) && !seen_nz_q && (idx_q != 2'd0)) begin
          hex_reg_d[idx_q] = SEG_OFF;
        end else begin
          hex_reg_d[idx_q] = seg;
        end
        if (nibble != 4'h0) begin
          seen_nz_d = 1'b1;
        end
        if (idx_q == 2'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q - 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == CNT_MAX) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated only with non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever order the statements run in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      lz_mode_q   <= 1'b0;
      idx_q       <= 2'd3;
      seen_nz_q   <= 1'b0;
      done_q      <= 1'b0;
      // NOTE: the digit registers drive pins, so they are reset to a known
      // "off" pattern. They are flops, not a RAM, and can be reset freely.
      hex_reg_q   <= {4{SEG_OFF}};
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      lz_mode_q   <= lz_mode_d;
      idx_q       <= idx_d;
      seen_nz_q   <= seen_nz_d;
      done_q      <= done_d;
      hex_reg_q   <= hex_reg_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Blink gating acts only on the outputs and never touches the digit registers.
  assign blank_all = blink_en && !phase_q;
  assign ready     = (state_q == ST_IDLE);
  assign done      = done_q;
  assign hex0      = blank_all ? SEG_OFF : hex_reg_q[0];
  assign hex1      = blank_all ? SEG_OFF : hex_reg_q[1];
  assign hex2      = blank_all ? SEG_OFF : hex_reg_q[2];
  assign hex3      = blank_all ? SEG_OFF : hex_reg_q[3];

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Self-checking bench for hex_display_sequencer: a table of load vectors checked
// through a scoreboard, plus hand-written reset, handshake and blink sequences.
module tb_hex_display_sequencer;

  localparam logic [6:0] OFF = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        ready, done;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [6:0]  e3, e2, e1, e0;
  } vec_t;

  vec_t vecs [8];
  vec_t sb [$];

  hex_display_sequencer #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .ready(ready), .done(done),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Segment patterns from the decoder table (active low, bit 6 = g).
  function automatic logic [6:0] seg(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] v, input logic b,
                              input logic [6:0] a3, input logic [6:0] a2,
                              input logic [6:0] a1, input logic [6:0] a0);
    vec_t r;
    r.value = v; r.blz = b; r.e3 = a3; r.e2 = a2; r.e1 = a1; r.e0 = a0;
    return r;
  endfunction

  // Waits (bounded) for done, then pops the oldest expectation and compares.
  task automatic wait_done(input string name);
    vec_t e;
    int   lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({name, "_done_latency"}, lat, 4);
    if (sb.size() == 0) begin
      check({name, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({name, "_hex3"}, {25'd0, hex3}, {25'd0, e.e3});
      check({name, "_hex2"}, {25'd0, hex2}, {25'd0, e.e2});
      check({name, "_hex1"}, {25'd0, hex1}, {25'd0, e.e1});
      check({name, "_hex0"}, {25'd0, hex0}, {25'd0, e.e0});
      check({name, "_ready"}, {31'd0, ready}, 1);
    end
  endtask

  // Single accepted load. Inputs are scrambled during UPDATE to show they are not resampled.
  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    check({name, "_ready_before"}, {31'd0, ready}, 1);
    value_in = v.value;
    blank_lz = v.blz;
    load     = 1'b1;
    @(posedge clk);
    #1;
    load     = 1'b0;
    value_in = ~v.value;
    blank_lz = ~v.blz;
    sb.push_back(v);
    wait_done(name);
  endtask

  initial begin
    logic [27:0] shown_4321;
    int          seen_done;

    vecs[0] = mk(16'h00A5, 1'b1, OFF, OFF, seg(10), seg(5));
    vecs[1] = mk(16'h0000, 1'b1, OFF, OFF, OFF, seg(0));
    vecs[2] = mk(16'h0305, 1'b1, OFF, seg(3), seg(0), seg(5));
    vecs[3] = mk(16'hFEDC, 1'b0, seg(15), seg(14), seg(13), seg(12));
    vecs[4] = mk(16'h0789, 1'b1, OFF, seg(7), seg(8), seg(9));
    vecs[5] = mk(16'h0010, 1'b1, OFF, OFF, seg(1), seg(0));
    vecs[6] = mk(16'h0000, 1'b0, seg(0), seg(0), seg(0), seg(0));
    vecs[7] = mk(16'hB006, 1'b1, seg(11), seg(0), seg(0), seg(6));

    // Asynchronous reset, asserted before any clock edge.
    #2 reset = 1'b1;
    #1;
    check("reset_hex", {hex3, hex2, hex1, hex0}, {4{OFF}});
    check("reset_ready", {31'd0, ready}, 1);
    check("reset_done", {31'd0, done}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full load 0x12AF, digit-by-digit timing.
    @(negedge clk);
    value_in = 16'h12AF; blank_lz = 1'b0; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0; value_in = 16'h0000;
    @(negedge clk);
    check("full_ready_low", {31'd0, ready}, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          check("full_hex3", {25'd0, hex3}, {25'd0, 7'b1111001});
          check("full_hex2_untouched", {25'd0, hex2}, {25'd0, OFF});
        end
        2: check("full_hex2", {25'd0, hex2}, {25'd0, 7'b0100100});
        3: check("full_hex1", {25'd0, hex1}, {25'd0, 7'b0001000});
        default: check("full_hex0", {25'd0, hex0}, {25'd0, 7'b0001110});
      endcase
      check($sformatf("full_ready_k%0d", k), {31'd0, ready}, (k == 4) ? 1 : 0);
      check($sformatf("full_done_k%0d", k), {31'd0, done}, (k == 4) ? 1 : 0);
    end
    @(negedge clk);
    check("full_done_one_cycle", {31'd0, done}, 0);

    // Table-driven loads.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Handshake: load held high with 0x2222 while busy is ignored, accepted at N+5.
    @(negedge clk);
    value_in = 16'h1111; blank_lz = 1'b0; load = 1'b1;
    @(posedge clk);
    #1 value_in = 16'h2222;
    sb.push_back(mk(16'h1111, 1'b0, seg(1), seg(1), seg(1), seg(1)));
    wait_done("hs_first");
    @(posedge clk);
    #1 load = 1'b0;
    sb.push_back(mk(16'h2222, 1'b0, seg(2), seg(2), seg(2), seg(2)));
    wait_done("hs_second");

    // Reset between edges N+2 and N+3 of a 0x8888 load.
    @(negedge clk);
    value_in = 16'h8888; blank_lz = 1'b0; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_hex", {hex3, hex2, hex1, hex0}, {4{OFF}});
    check("midrst_ready", {31'd0, ready}, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    check("midrst_no_done", seen_done, 0);
    check("midrst_still_off", {hex3, hex2, hex1, hex0}, {4{OFF}});
    apply(mk(16'h0001, 1'b0, seg(0), seg(0), seg(0), seg(1)), "after_rst");

    // Blink with BLINK_DIV=4 on display 0x4321.
    apply(mk(16'h4321, 1'b0, seg(4), seg(3), seg(2), seg(1)), "blink_load");
    shown_4321 = {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    @(negedge clk);
    blink_en = 1'b1;
    #1 check("blink_rise_on", {hex3, hex2, hex1, hex0}, shown_4321);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("blink_e%0d", i), {hex3, hex2, hex1, hex0},
            ((((i + 1) / 4) % 2) == 0) ? shown_4321 : {4{OFF}});
    end
    blink_en = 1'b0;
    @(negedge clk);
    check("blink_drop_visible", {hex3, hex2, hex1, hex0}, shown_4321);
    blink_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("blink_fresh_e%0d", i), {hex3, hex2, hex1, hex0},
            (i < 3) ? shown_4321 : {4{OFF}});
    end
    blink_en = 1'b0;
    @(negedge clk);
    check("blink_final_visible", {hex3, hex2, hex1, hex0}, shown_4321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hex_display_sequencer.md
# hex_display_sequencer

Loads a 16-bit value into four HEX digit registers through one shared 4-bit-to-7-segment (active-low) decoder instance. The block steps that decoder across the digits, most significant first, and captures each result into a per-digit output register. It also handles optional leading-zero blanking, a valid/ready load handshake, and an optional blink of the whole display. It sits between the register-file lab datapath (the value source) and the board HEX0–HEX3 pins.

## Interface
- BLINK_DIV, default 25_000_000: clock cycles per blink half-period; minimum 2.
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- value_in  input  16  value to display; nibble k drives HEXk.
- load  input  1  load request; accepted on a rising edge where load && ready.
- blank_lz  input  1  leading-zero blanking enable; sampled with the accepted load.
- blink_en  input  1  blink enable; level-sensitive, live.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when all four digits are updated.
- hex0..hex3  output  7 each  segment outputs, active low, bit 6 = g … bit 0 = a.

## Operation
- States are IDLE and UPDATE. Reset enters IDLE.
- **Accepting a load.** In IDLE, load && ready at an edge does the following:
  - shadow ← value_in, lz_mode ← blank_lz, idx ← 3, seen_nz ← 0.
  - The state moves to UPDATE.
- **Ignored loads.** load while ready=0 is ignored. It is not queued, and shadow is unchanged.
- **UPDATE, one digit per cycle.** The decoder input is shadow[4*idx+3 : 4*idx]. At each edge in UPDATE:
  - If lz_mode=1, the nibble is 0, seen_nz=0 and idx≠0, then hex_reg[idx] ← 7'b1111111 (blank).
  - Otherwise hex_reg[idx] ← decoder output.
  - If the nibble ≠ 0, seen_nz ← 1.
  - If idx=0, the state moves to IDLE and done pulses. Otherwise idx ← idx−1.
- **Digit 0 is never blanked.** Value 0 therefore displays as a single "0".
- **Digits are independent.** Digits not yet rewritten keep their previous value during UPDATE; there is no global clear between loads.
- **Decoder table (active low).**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Blink counter.**
  - While blink_en=0, blink_cnt is held at 0 and phase=1 (on).
  - While blink_en=1, blink_cnt increments every cycle. At BLINK_DIV−1 it wraps to 0 and phase toggles.
  - Dropping blink_en restores phase=1 on the next edge. Re-raising it starts a fresh on-half.
- **Output gating.** hexk = (blink_en && !phase) ? 7'b1111111 : hex_reg[k].
  - Gating is output-only: hex_reg and UPDATE sequencing are unaffected by blink.
  - Blink and update may overlap freely.

## Timing
- **Reset (asynchronous).** Takes effect immediately, with no clock needed:
  - State IDLE, ready=1, done=0.
  - All hex_reg = 7'b1111111, so hex0..hex3 are all off.
  - shadow=0, idx=3, seen_nz=0, lz_mode=0, blink_cnt=0, phase=1.
- **Reset mid-UPDATE.** Aborts the update. All digits return to off; no done pulse.
- **Load accepted at edge N:**
  - ready=0 from edge N through edge N+4.
  - hex3 updates at edge N+1, hex2 at N+2, hex1 at N+3, hex0 at N+4.
  - done=1 during the cycle after edge N+4, and ready=1 in that same cycle.
- **Latency and throughput.** Latency from accept to final digit is 4 edges. The earliest next accept is edge N+5, so maximum throughput is one load per 5 cycles.
- **Input stability.** value_in and blank_lz are only sampled at accept; changes during UPDATE have no effect.
- **Blink period.** The full blink period is 2·BLINK_DIV cycles. The first off-half begins BLINK_DIV cycles after blink_en rises.

## Test plan
- **Reset.** Assert reset mid-cycle without a clock -> hex0..hex3=1111111, ready=1, done=0 immediately.
- **Full load, no blanking.** Load 0x12AF with blank_lz=0 at edge N:
  - hex3=1111001 at N+1, hex2=0100100 at N+2, hex1=0001000 at N+3, hex0=0001110 at N+4.
  - done pulse in cycle N+4..N+5; ready low for exactly 4 cycles.
- **Leading-zero blanking.**
  - Load 0x00A5 with blank_lz=1 -> hex3=hex2=1111111, hex1=0001000, hex0=0010010.
  - Load 0x0000 with blank_lz=1 -> hex3..hex1 blank, hex0=1000000.
  - Load 0x0305 with blank_lz=1 -> hex3 blank, hex2=0110000, hex1=1000000 (inner zero shown), hex0=0010010.
- **Handshake.**
  - Load 0x1111, then assert load with 0x2222 on edges N+1..N+4 -> ignored; display stays 1111.
  - Load 0x2222 at N+5 -> accepted; display becomes 2222 by N+9.
- **Reset mid-update.** Reset asserted between edges N+2 and N+3 of a 0x8888 load:
  - All digits off; no done pulse.
  - A subsequent load of 0x0001 with blank_lz=0 displays 0001.
- **Blink.** With BLINK_DIV=4 and display 0x4321, raise blink_en:
  - Outputs show 4321 for 4 cycles, all-off for 4, then 4321 again.
  - Lower blink_en during an off-half -> digits visible after the next edge; hex_reg unchanged.
